// File: rtl/softmax_pkg.sv
// Shared types and sizing helpers for the softmax normaliser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package softmax_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_FRAC    = 8;
    localparam int DEF_VEC_LEN = 4;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_DIV  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Accumulator width: each clamped element is at most 2^(width-1)-1,
    // so vec_len of them never overflow width-1+clog2(vec_len) bits.
    function automatic int sum_width(input int width, input int vec_len);
        return width - 1 + $clog2(vec_len);
    endfunction

endpackage

// File: rtl/div_restoring_seq.sv
// Unsigned restoring divider producing one quotient bit per cycle.
// Latency: done pulses QW cycles after the cycle start is sampled.
// Backpressure: none; quo holds its value until the next start.
module div_restoring_seq
    import softmax_pkg::*;
#(
    parameter int NW = 23,
    parameter int DW = 17,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          done,
    output logic [QW-1:0] quo
);

    localparam int CW = $clog2(QW + 1);

    // Only the low QW quotient bits are developed: the caller guarantees
    // num >> QW < den, so the upper bits are zero and the bits above QW
    // can be preloaded straight into the partial remainder.
    logic [DW-1:0] rem;
    logic [DW-1:0] rem_nxt;
    logic [DW-1:0] den_r;
    logic [QW-1:0] nsh;
    logic [CW-1:0] cnt;
    logic          active;
    logic [DW:0]   trial;
    logic          ge;

    // One restoring step: shift in the next numerator bit and try a subtract.
    always_comb begin
        trial   = {rem, nsh[QW-1]};
        ge      = (trial >= {1'b0, den_r});
        rem_nxt = ge ? DW'(trial - {1'b0, den_r}) : trial[DW-1:0];
    end

    // Iteration state; done is registered together with the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            den_r  <= '0;
            nsh    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
            quo    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem    <= DW'(num >> QW);
                nsh    <= num[QW-1:0];
                den_r  <= den;
                quo    <= '0;
                cnt    <= CW'(QW);
                active <= 1'b1;
            end else if (active) begin
                rem <= rem_nxt;
                nsh <= nsh << 1;
                quo <= {quo[QW-2:0], ge};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers a vector of exp values, sums them, emits e_i/sum.
// Latency: first output WIDTH+2 cycles after the last input beat; WIDTH+2 per later element.
// Backpressure: in_ready low outside loading; output held stable while out_ready is low.
module softmax_norm
    import softmax_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int FRAC    = DEF_FRAC,
    parameter int VEC_LEN = DEF_VEC_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int SW = sum_width(WIDTH, VEC_LEN);
    localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int NW = WIDTH - 1 + FRAC;
    localparam logic [IW-1:0]    LAST_IDX = IW'(VEC_LEN - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1) << FRAC;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    idx;
    logic [SW-1:0]    sum;
    // Clamped values are non-negative, so the sign bit is not stored.
    logic [WIDTH-2:0] ebuf [VEC_LEN];
    logic [WIDTH-2:0] elem;
    logic             is_last;
    logic             div_pend;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [NW-1:0]    div_num;

    assign elem    = in_data[WIDTH-1] ? '0 : in_data[WIDTH-2:0];
    assign is_last = (idx == LAST_IDX);
    assign div_num = {ebuf[idx], {FRAC{1'b0}}};

    // Each element is at most the sum, so the quotient never exceeds 1.0
    // and fits in WIDTH bits; the divider only develops those bits.
    div_restoring_seq #(
        .NW (NW),
        .DW (SW),
        .QW (WIDTH)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (sum),
        .done  (div_done),
        .quo   (div_quo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    // Next-state logic; a zero sum bypasses the divider entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (in_valid && is_last)          state_nxt = S_DIV;
            S_DIV:  if ((sum == '0) || div_done)      state_nxt = S_OUT;
            S_OUT:  if (out_ready)                    state_nxt = is_last ? S_LOAD : S_DIV;
            default:                                  state_nxt = S_LOAD;
        endcase
    end

    // State-decoded outputs; all purely combinational so reset shows at once.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        div_start = 1'b0;
        case (state)
            S_LOAD: in_ready = 1'b1;
            S_DIV: begin
                busy      = 1'b1;
                div_start = !div_pend && (sum != '0);
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = is_last;
            end
            default: ;
        endcase
    end

    // Buffer, accumulator, element index and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            sum      <= '0;
            div_pend <= 1'b0;
            out_data <= '0;
            for (int i = 0; i < VEC_LEN; i++) ebuf[i] <= '0;
        end else begin
            if (div_start)     div_pend <= 1'b1;
            else if (div_done) div_pend <= 1'b0;

            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        ebuf[idx] <= elem;
                        sum       <= sum + SW'(elem);
                        idx       <= is_last ? '0 : idx + 1'b1;
                    end
                end
                S_DIV: begin
                    if (sum == '0)
                        out_data <= '0;
                    else if (div_done)
                        out_data <= (div_quo > ONE) ? ONE : div_quo;
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (is_last) begin
                            idx <= '0;
                            sum <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm.sv
module tb_softmax_norm;

    localparam int WIDTH   = 16;
    localparam int FRAC    = 8;
    localparam int VEC_LEN = 4;
    localparam int TMO     = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    softmax_norm #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .VEC_LEN (VEC_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat and return at the negedge after it was accepted.
    task automatic send_beat(input int v);
        int n;
        in_valid = 1'b1;
        in_data  = WIDTH'(v);
        n = 0;
        while (!in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) chk("in_ready_wait", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        send_beat(a);
        send_beat(b);
        send_beat(c);
        send_beat(d);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Wait for an output, check it, and consume it (out_ready assumed high).
    task automatic recv(input string tag, input int exp_d, input int exp_l, output int waits);
        waits = 0;
        while (!out_valid && waits < TMO) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= TMO) chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_last"}, out_last, exp_l);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int t_a;
        int t_b;
        int va [8];
        int ea [8];
        va = '{256, 256, 256, 256, 77, 256, 0, 0};
        ea = '{64, 64, 64, 64, 59, 196, 0, 0};
        t_a = 0;
        t_b = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Uniform vector, with first-output latency
        send4(256, 256, 256, 256);
        recv("t1_e0", 64, 0, w);
        chk("t1_latency", w, WIDTH + 2);
        recv("t1_e1", 64, 0, w);
        chk("t1_latency_e1", w, WIDTH + 2);
        recv("t1_e2", 64, 0, w);
        recv("t1_e3", 64, 1, w);
        chk("t1_idle_ready", in_ready, 1);

        // 2. exp(-1.2) style vector, truncated quotients
        send4(77, 256, 0, 0);
        recv("t2_e0", 59, 0, w);
        recv("t2_e1", 196, 0, w);
        recv("t2_e2", 0, 0, w);
        recv("t2_e3", 0, 1, w);

        // 3. Negative clamp, then an all-zero vector
        send4(-5, 256, 256, 0);
        recv("t3_e0", 0, 0, w);
        recv("t3_e1", 128, 0, w);
        recv("t3_e2", 128, 0, w);
        recv("t3_e3", 0, 1, w);
        send4(0, 0, 0, 0);
        recv("t3z_e0", 0, 0, w);
        chk("t3z_lat_e0", w, 1);
        recv("t3z_e1", 0, 0, w);
        chk("t3z_lat_e1", w, 1);
        recv("t3z_e2", 0, 0, w);
        recv("t3z_e3", 0, 1, w);

        // 4. Backpressure on element 2
        send4(512, 256, 256, 0);
        recv("t4_e0", 128, 0, w);
        out_ready = 1'b0;
        w = 0;
        while (!out_valid && w < TMO) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", out_data, 64);
            chk("t4_hold_last", out_last, 0);
            chk("t4_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("t4_hold_busy", busy, 1);
        out_ready = 1'b1;
        recv("t4_e1", 64, 0, w);
        recv("t4_e2", 64, 0, w);
        recv("t4_e3", 0, 1, w);

        // 5. Asynchronous reset during the divide of element 1
        send4(256, 256, 256, 256);
        recv("t5_e0", 64, 0, w);
        repeat (5) @(negedge clk);
        chk("t5_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_in_ready", in_ready, 1);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_out_data", out_data, 0);
        chk("t5_rst_out_last", out_last, 0);
        chk("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send4(256, 0, 0, 0);
        recv("t5_f0", 256, 0, w);
        recv("t5_f1", 0, 0, w);
        recv("t5_f2", 0, 0, w);
        recv("t5_f3", 0, 1, w);

        // 6. Back-to-back vectors with in_valid held high
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_beat(va[i]);
                    if (i == 4) t_b = cyc;
                end
                in_valid = 1'b0;
                in_data  = '0;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    recv("t6_out", ea[k], (k == 3 || k == 7) ? 1 : 0, w);
                    if (k == 3) t_a = cyc;
                end
            end
        join
        chk("t6_second_start", t_b, t_a + 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
